// File: rtl/vram_pkg.sv
// Shared VRAM types and default bus widths, also used by the timing and tile-render blocks.
package vram_pkg;

  localparam int unsigned VRAM_ADDR_W = 16;
  localparam int unsigned VRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_A    = 2'd2,
    TAG_B    = 2'd3
  } tag_t;

  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus: display fetch, ports A/B and the single-port RAM command/data signals.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W
);

  logic              blank;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_rvalid;

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic              a_rvalid;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic              b_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  blank, disp_req, disp_addr,
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  ram_rdata,
    output disp_rvalid, a_ack, a_rvalid, b_ack, b_rvalid, rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  // Requesters and RAM side
  modport master (
    output blank, disp_req, disp_addr,
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output ram_rdata,
    input  disp_rvalid, a_ack, a_rvalid, b_ack, b_rvalid, rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/vram_rd_tag_pipe.sv
// Read-tag shift register (RD_LAT+1 deep) steering registered RAM read data to its requester.
module vram_rd_tag_pipe
  import vram_pkg::*;
#(
  parameter int unsigned DATA_W = VRAM_DATA_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  tag_t              tag_in,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              disp_rvalid,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata
);

  tag_t              tag_q [RD_LAT+1];
  tag_t              tag_d [RD_LAT+1];
  logic              disp_rvalid_q, disp_rvalid_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  tag_t              tag_end;

  // Stage 0 lines up with the RAM command; the last stage lines up with ram_rdata.
  always_comb begin
    tag_d[0] = tag_in;
    for (int unsigned i = 1; i <= RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    tag_end       = tag_q[RD_LAT];
    disp_rvalid_d = (tag_end == TAG_DISP);
    a_rvalid_d    = (tag_end == TAG_A);
    b_rvalid_d    = (tag_end == TAG_B);
    rdata_d       = (tag_end != TAG_NONE) ? ram_rdata : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= RD_LAT; i++) begin
        tag_q[i] <= TAG_NONE;
      end
      disp_rvalid_q <= 1'b0;
      a_rvalid_q    <= 1'b0;
      b_rvalid_q    <= 1'b0;
      rdata_q       <= '0;
    end else begin
      for (int unsigned i = 0; i <= RD_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
      disp_rvalid_q <= disp_rvalid_d;
      a_rvalid_q    <= a_rvalid_d;
      b_rvalid_q    <= b_rvalid_d;
      rdata_q       <= rdata_d;
    end
  end

  assign disp_rvalid = disp_rvalid_q;
  assign a_rvalid    = a_rvalid_q;
  assign b_rvalid    = b_rvalid_q;
  assign rdata       = rdata_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has absolute priority, ports A/B share the rest round-robin.
// Optional VRAM_BLANK_ONLY_EN: A/B writes are only granted while blank is high.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W,
  parameter int unsigned RD_LAT = 1
) (
  input logic           sys_clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);

  rr_t               rr_ptr_q, rr_ptr_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  tag_t              tag_d;
  logic              elig_a, elig_b;

  always_comb begin
    // A port acked this cycle is still holding its old request; skip it.
    elig_a = bus.a_req && !a_ack_q;
    elig_b = bus.b_req && !b_ack_q;
`ifdef VRAM_BLANK_ONLY_EN
    elig_a = elig_a && (!bus.a_we || bus.blank);
    elig_b = elig_b && (!bus.b_we || bus.blank);
`endif
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (!bus.disp_req) begin
      if (elig_a && elig_b) begin
        a_ack_d  = (rr_ptr_q == RR_A);
        b_ack_d  = (rr_ptr_q == RR_B);
        rr_ptr_d = (rr_ptr_q == RR_A) ? RR_B : RR_A;
      end else begin
        a_ack_d = elig_a;
        b_ack_d = elig_b;
      end
    end

    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    tag_d       = TAG_NONE;
    if (bus.disp_req) begin
      ram_en_d   = 1'b1;
      ram_addr_d = bus.disp_addr;
      tag_d      = TAG_DISP;
    end else if (a_ack_d) begin
      ram_en_d    = 1'b1;
      ram_we_d    = bus.a_we;
      ram_addr_d  = bus.a_addr;
      ram_wdata_d = bus.a_wdata;
      tag_d       = bus.a_we ? TAG_NONE : TAG_A;
    end else if (b_ack_d) begin
      ram_en_d    = 1'b1;
      ram_we_d    = bus.b_we;
      ram_addr_d  = bus.b_addr;
      ram_wdata_d = bus.b_wdata;
      tag_d       = bus.b_we ? TAG_NONE : TAG_B;
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= RR_A;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
    end
  end

`ifndef VRAM_BLANK_ONLY_EN
  logic unused_blank;
  assign unused_blank = bus.blank;
`endif

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.a_ack     = a_ack_q;
  assign bus.b_ack     = b_ack_q;

  logic              disp_rvalid_w, a_rvalid_w, b_rvalid_w;
  logic [DATA_W-1:0] rdata_w;

  vram_rd_tag_pipe #(
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk        (sys_clk),
    .rst_n      (reset),
    .tag_in     (tag_d),
    .ram_rdata  (bus.ram_rdata),
    .disp_rvalid(disp_rvalid_w),
    .a_rvalid   (a_rvalid_w),
    .b_rvalid   (b_rvalid_w),
    .rdata      (rdata_w)
  );

  assign bus.disp_rvalid = disp_rvalid_w;
  assign bus.a_rvalid    = a_rvalid_w;
  assign bus.b_rvalid    = b_rvalid_w;
  assign bus.rdata       = rdata_w;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a 1-cycle-latency RAM model; honours VRAM_BLANK_ONLY_EN.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .RD_LAT(LAT)
  ) dut (
    .sys_clk(clk),
    .reset  (rst_n),
    .bus    (bus)
  );

  logic [DW-1:0] mem [65536];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.ram_en && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= mem[bus.ram_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    pre_en   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    tick();
    pre_en   = 1'b0;
  endtask

  logic exp_a;

  initial begin
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    bus.blank = 1'b1; bus.disp_req = 1'b0; bus.disp_addr = '0;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    bus.ram_rdata = '0;

    preload(16'h0123, 16'hBEEF);
    preload(16'h0200, 16'h1111);
    preload(16'h0201, 16'h2222);
    preload(16'h0202, 16'h3333);
    preload(16'h0010, 16'hAAAA);
    preload(16'h0020, 16'hBBBB);

    // Reset state
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    chk("rst_acks", {bus.a_ack, bus.b_ack}, 0);
    chk("rst_rvalids", {bus.disp_rvalid, bus.a_rvalid, bus.b_rvalid}, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rr", dut.rr_ptr_q, 0);

    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_ram_en", bus.ram_en, 0);
      chk("idle_rvalids", {bus.disp_rvalid, bus.a_rvalid, bus.b_rvalid}, 0);
    end

    // Port A read
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h0123;
    tick();
    chk("rda_ack", bus.a_ack, 1);
    chk("rda_ram_en", bus.ram_en, 1);
    chk("rda_ram_we", bus.ram_we, 0);
    chk("rda_ram_addr", bus.ram_addr, 16'h0123);
    tick();
    chk("rda_no_double_ack", bus.a_ack, 0);
    chk("rda_idle_en", bus.ram_en, 0);
    chk("rda_early_rvalid", bus.a_rvalid, 0);
    bus.a_req = 1'b0;
    tick();
    chk("rda_rvalid", bus.a_rvalid, 1);
    chk("rda_rdata", bus.rdata, 16'hBEEF);
    chk("rda_other_rvalid", {bus.disp_rvalid, bus.b_rvalid}, 0);
    tick();
    chk("rda_rvalid_pulse", bus.a_rvalid, 0);
    repeat (3) tick();

    // Display priority
    bus.disp_req = 1'b1; bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h0123;
    for (int k = 0; k < 3; k++) begin
      bus.disp_addr = 16'h0200 + 16'(k);
      tick();
      chk("disp_ram_en", bus.ram_en, 1);
      chk("disp_ram_we", bus.ram_we, 0);
      chk("disp_ram_addr", bus.ram_addr, 32'h0200 + 32'(k));
      chk("disp_a_blocked", bus.a_ack, 0);
    end
    chk("disp_rvalid0", bus.disp_rvalid, 1);
    chk("disp_rdata0", bus.rdata, 16'h1111);
    bus.disp_req = 1'b0;
    tick();
    chk("disp_a_ack", bus.a_ack, 1);
    chk("disp_a_addr", bus.ram_addr, 16'h0123);
    chk("disp_rvalid1", bus.disp_rvalid, 1);
    chk("disp_rdata1", bus.rdata, 16'h2222);
    tick();
    chk("disp_a_ack_pulse", bus.a_ack, 0);
    chk("disp_rvalid2", bus.disp_rvalid, 1);
    chk("disp_rdata2", bus.rdata, 16'h3333);
    bus.a_req = 1'b0;
    tick();
    chk("disp_a_rvalid", {bus.disp_rvalid, bus.a_rvalid}, 2'b01);
    chk("disp_a_rdata", bus.rdata, 16'hBEEF);
    repeat (3) tick();

    // A/B contention; a display cycle after each grant lets the acked port re-raise
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h0010;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 16'h0020;
    bus.disp_addr = 16'h0200;
    for (int g = 0; g < 4; g++) begin
      bus.disp_req = 1'b0;
      tick();
      exp_a = (g % 2 == 0);
      chk("cont_a_ack", bus.a_ack, 32'(exp_a));
      chk("cont_b_ack", bus.b_ack, 32'(!exp_a));
      chk("cont_ram_addr", bus.ram_addr, exp_a ? 32'h0010 : 32'h0020);
      chk("cont_rr", dut.rr_ptr_q, 32'(exp_a));
      bus.disp_req = 1'b1;
      tick();
      chk("cont_disp_gap", {bus.a_ack, bus.b_ack}, 0);
    end
    bus.disp_req = 1'b0; bus.a_req = 1'b0; bus.b_req = 1'b0;
    repeat (5) tick();

    // Port B write, then readback through A
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 16'h0040; bus.b_wdata = 16'h5A5A;
    tick();
    chk("wrb_ack", bus.b_ack, 1);
    chk("wrb_ram_en_we", {bus.ram_en, bus.ram_we}, 2'b11);
    chk("wrb_ram_addr", bus.ram_addr, 16'h0040);
    chk("wrb_ram_wdata", bus.ram_wdata, 16'h5A5A);
    tick();
    chk("wrb_idle_en", bus.ram_en, 0);
    chk("wrb_hold_addr", bus.ram_addr, 16'h0040);
    chk("wrb_hold_wdata", bus.ram_wdata, 16'h5A5A);
    bus.b_req = 1'b0; bus.b_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("wrb_no_rvalid", {bus.disp_rvalid, bus.a_rvalid, bus.b_rvalid}, 0);
    end
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h0040;
    tick();
    chk("rdb_ack", bus.a_ack, 1);
    tick();
    bus.a_req = 1'b0;
    tick();
    chk("rdb_rvalid", bus.a_rvalid, 1);
    chk("rdb_rdata", bus.rdata, 16'h5A5A);
    repeat (3) tick();

    // Write during active display
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 16'h0050; bus.a_wdata = 16'h1234;
`ifdef VRAM_BLANK_ONLY_EN
    bus.blank = 1'b0;
    bus.b_we = 1'b0; bus.b_addr = 16'h0123;
    for (int i = 0; i < 10; i++) begin
      bus.b_req = (i == 3 || i == 4);
      tick();
      chk("blk_a_wait", bus.a_ack, 0);
      chk("blk_b_read", bus.b_ack, 32'(i == 3));
    end
    bus.b_req = 1'b0;
    bus.blank = 1'b1;
    tick();
`else
    bus.blank = 1'b0;
    tick();
`endif
    chk("blk_a_ack", bus.a_ack, 1);
    chk("blk_ram_we", bus.ram_we, 1);
    chk("blk_ram_addr", bus.ram_addr, 16'h0050);
    tick();
    chk("blk_a_ack_pulse", bus.a_ack, 0);
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.blank = 1'b1;
    repeat (4) tick();

    // Reset while a read is in flight
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h0123;
    tick();
    chk("mrst_ack", bus.a_ack, 1);
    bus.a_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ram_en", bus.ram_en, 0);
    chk("mrst_ack_clr", bus.a_ack, 0);
    chk("mrst_ram_addr", bus.ram_addr, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mrst_no_rvalid", {bus.disp_rvalid, bus.a_rvalid, bus.b_rvalid}, 0);
      chk("mrst_idle", bus.ram_en, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
